// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe
// ---------------
// Two-stage pipelined modular adder/subtractor for the NTT/polynomial
// datapath. Each operation computes (a+b) mod q or (a-b) mod q, with the
// modulus q supplied per operation alongside a sideband tag that is passed
// through unchanged.
//
// Optional build macro: MOD_ADDSUB_RANGE_CHK_EN
//   When defined, operands that break the range preconditions
//   (a >= q, b >= q or q < 2) are flagged on err_o, and c_o is forced to 0
//   for those operations. When undefined, the err_o port and the check
//   logic do not exist.
//
// Parameters:
//   W      operand / modulus / result width (q < 2^W)
//   TAG_W  sideband tag width
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; drops in-flight operations
//   in_valid_i   input operation valid
//   in_ready_o   block accepts an input this cycle
//   op_i         0 = add, 1 = subtract
//   a_i, b_i     operands (expected < q_i)
//   q_i          modulus (expected 2 <= q_i <= 2^W-1)
//   tag_i        sideband tag
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   c_o          result in [0, q-1]
//   tag_o        tag of the operation that produced c_o
//   err_o        range-check flag (only with MOD_ADDSUB_RANGE_CHK_EN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid must keep its payload stable until the
// transfer; ready may depend combinationally on the consumer's ready
// (in_ready_o = !out_valid_o || out_ready_i) but never on in_valid_i.
module mod_addsub_pipe #(
  parameter int W     = 23,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             op_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     q_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     c_o,
  output logic [TAG_W-1:0] tag_o
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic             err_o
`endif
);

  // Both stages move as one; a stall freezes the whole pipe and bubbles are
  // carried along rather than squeezed out.
  logic advance;
  logic in_accept;

  // Stage 1 registers
  logic             v1;
  logic [W:0]       r1;    // a+b (add) or {0,a}-{0,b} (sub, MSB = borrow)
  logic             op1;
  logic [W-1:0]     q1;
  logic [TAG_W-1:0] tag1;

  // Stage 2 valid
  logic v2;

  // Stage 1 combinational result
  logic [W:0] r1_next;

  // Stage 2 combinational correction
  logic [W:0]   add_minus_q;
  logic [W-1:0] c_next;

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic chk1;
  logic chk_next;
`endif

  assign advance     = !v2 || out_ready_i;
  assign in_ready_o  = advance;
  assign in_accept   = in_valid_i && advance;
  assign out_valid_o = v2;

  // The W+1 bit result keeps the carry of a+b (up to 2q-2) and the borrow
  // of a-b, so neither case can overflow even for q = 2^W-1.
  assign r1_next = op_i ? ({1'b0, a_i} - {1'b0, b_i})
                        : ({1'b0, a_i} + {1'b0, b_i});

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  assign chk_next = (a_i >= q_i) || (b_i >= q_i) || (q_i < W'(2));
`endif

  assign add_minus_q = r1 - {1'b0, q1};

  always_comb begin
    c_next = '0;
    if (op1) begin
      // A borrow means a < b: wrap back into range by adding q. The sum is
      // taken mod 2^W, which is exactly the low W bits of (a-b+q).
      c_next = r1[W] ? (r1[W-1:0] + q1) : r1[W-1:0];
    end else begin
      c_next = (r1 >= {1'b0, q1}) ? add_minus_q[W-1:0] : r1[W-1:0];
    end
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    if (chk1) begin
      c_next = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1    <= 1'b0;
      r1    <= '0;
      op1   <= 1'b0;
      q1    <= '0;
      tag1  <= '0;
      v2    <= 1'b0;
      c_o   <= '0;
      tag_o <= '0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      chk1  <= 1'b0;
      err_o <= 1'b0;
`endif
    end else if (advance) begin
      v1    <= in_accept;
      r1    <= r1_next;
      op1   <= op_i;
      q1    <= q_i;
      tag1  <= tag_i;
      v2    <= v1;
      c_o   <= c_next;
      tag_o <= tag1;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      chk1  <= chk_next;
      err_o <= chk1;
`endif
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Testbench for mod_addsub_pipe: directed cases with fixed expected values,
// a stalled stream, reset with operations in flight, and a randomized stream
// checked against a plain-arithmetic modular reference model.
module tb_mod_addsub_pipe;

  localparam int W     = 23;
  localparam int TAG_W = 4;
  localparam int EW    = 1 + TAG_W + W;   // {err, tag, c}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     q;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     c;
  logic [TAG_W-1:0] tago;
  logic             err_obs;

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic err_w;
  assign err_obs = err_w;
`else
  assign err_obs = 1'b0;
`endif

  mod_addsub_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .q_i         (q),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .c_o         (c),
    .tag_o       (tago)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    ,
    .err_o       (err_w)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [EW-1:0] exp_q[$];

  logic [W-1:0]     hold_c;
  logic [TAG_W-1:0] hold_t;
  int               base_out;
  bit               rand_done;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
    end
  endtask

  // Reference: modular arithmetic straight from the definition.
  function automatic logic [EW-1:0] model(input logic o, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic [W-1:0] qv,
                                          input logic [TAG_W-1:0] tv);
    longint unsigned la, lb, lq, r;
    logic e;
    la = av; lb = bv; lq = qv;
    e = 1'b0;
    r = 0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    e = (av >= qv) || (bv >= qv) || (qv < 2);
`endif
    if (!e) begin
      if (o) r = (la + lq - lb) % lq;
      else   r = (la + lb) % lq;
    end
    return {e, tv, r[W-1:0]};
  endfunction

  // Every accepted output is popped against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", out_valid, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_c", c, e[W-1:0]);
        check("out_tag", tago, e[W +: TAG_W]);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        check("out_err", err_obs, e[EW-1]);
`endif
        n_out++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks begin and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] qv, input logic [TAG_W-1:0] tv);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; op = o; a = av; b = bv; q = qv; tag = tv;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back(model(o, av, bv, qv, tv));
    else    check("push_timeout_in_ready", in_ready, 1);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [W-1:0] ec,
                            input logic [TAG_W-1:0] et, input logic ee);
    @(negedge clk);
    check({name, "_valid"}, out_valid, v);
    if (v) begin
      check({name, "_c"}, c, ec);
      check({name, "_tag"}, tago, et);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      check({name, "_err"}, err_obs, ee);
`endif
    end
    step();
  endtask

  // One operation through an empty pipe: not valid one cycle after the
  // accepting edge, valid with the result the cycle after that.
  task automatic run_one(input string name, input logic o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] qv,
                         input logic [TAG_W-1:0] tv, input logic [W-1:0] ec);
    push(o, av, bv, qv, tv);
    expect_out({name, "_lat1"}, 1'b0, '0, '0, 1'b0);
    expect_out(name, 1'b1, ec, tv, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; q = W'(2); tag = '0;
    out_ready = 1'b1;
    rand_done = 1'b0;
    step();
    step();
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_c", c, 0);
    check("reset_tag", tago, 0);
    check("reset_err", err_obs, 0);
    check("reset_in_ready", in_ready, 1);
    step();
    rst = 1'b0;

    // Back-to-back adds, q = 40
    push(1'b0, 23'd20, 23'd3, 23'd40, 4'd1);
    push(1'b0, 23'd20, 23'd21, 23'd40, 4'd2);
    expect_out("t1_first", 1'b1, 23'd23, 4'd1, 1'b0);
    expect_out("t1_second", 1'b1, 23'd1, 4'd2, 1'b0);
    expect_out("t1_empty", 1'b0, '0, '0, 1'b0);

    // Subtraction cases, q = 40
    run_one("t2_borrow", 1'b1, 23'd3, 23'd20, 23'd40, 4'd3, 23'd23);
    run_one("t2_equal", 1'b1, 23'd20, 23'd20, 23'd40, 4'd4, 23'd0);
    run_one("t2_zero_minus_max", 1'b1, 23'd0, 23'd39, 23'd40, 4'd5, 23'd1);

    // Large moduli
    run_one("t3_dil_add", 1'b0, 23'd8380416, 23'd8380416, 23'd8380417, 4'd6, 23'd8380415);
    run_one("t3_dil_sub", 1'b1, 23'd0, 23'd1, 23'd8380417, 4'd7, 23'd8380416);
    run_one("t3_qmax_add", 1'b0, 23'd8388606, 23'd8388606, 23'd8388607, 4'd8, 23'd8388605);
    run_one("t3_qmax_sub", 1'b1, 23'd0, 23'd8388606, 23'd8388607, 4'd9, 23'd1);

    // Stream of 8 with a 3-cycle output stall in the middle
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          push(i[0], W'($urandom_range(0, 999)), W'($urandom_range(0, 999)), 23'd1000, TAG_W'(i));
      end
      begin
        step(); step(); step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_in_ready_stalled", in_ready, 0);
        check("t4_valid_stalled", out_valid, 1);
        hold_c = c;
        hold_t = tago;
        step();
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("t4_in_ready_stalled", in_ready, 0);
          check("t4_c_hold", c, hold_c);
          check("t4_tag_hold", tago, hold_t);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain("t4");
    check("t4_out_count", n_out - base_out, 8);

    // Reset with two operations in flight
    out_ready = 1'b0;
    push(1'b0, 23'd1, 23'd2, 23'd40, 4'd10);
    push(1'b0, 23'd3, 23'd4, 23'd40, 4'd11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    expect_out("t5_flushed0", 1'b0, '0, '0, 1'b0);
    expect_out("t5_flushed1", 1'b0, '0, '0, 1'b0);
    expect_out("t5_flushed2", 1'b0, '0, '0, 1'b0);
    run_one("t5_after_reset", 1'b0, 23'd5, 23'd6, 23'd40, 4'd12, 23'd11);

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    push(1'b0, 23'd40, 23'd1, 23'd40, 4'd13);
    expect_out("t6_err_lat1", 1'b0, '0, '0, 1'b0);
    expect_out("t6_err", 1'b1, 23'd0, 4'd13, 1'b1);
    run_one("t6_ok", 1'b0, 23'd1, 23'd1, 23'd40, 4'd14, 23'd2);
`endif

    // Randomized stream with random backpressure
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [W-1:0] qv;
          qv = W'($urandom_range(2, 8388607));
          push(1'($urandom_range(0, 1)), W'($urandom_range(0, qv - 1)),
               W'($urandom_range(0, qv - 1)), qv, TAG_W'($urandom_range(0, 15)));
          if ($urandom_range(0, 4) == 0) step();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain("rand");
    check("rand_out_count", n_out - base_out, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
Pipelined, parametrised modular adder/subtractor for the NTT/polynomial datapath. It computes (a+b) mod q or (a-b) mod q on operands of configurable width, with a per-operation mode bit and a sideband tag. It has a 2-stage pipeline and valid/ready handshakes on input and output, and it sits between the operand fetch logic and the butterfly/accumulate units.

Parameters:
W, 23, operand, modulus and result width in bits (q < 2^W)
TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-high
in_valid_i  input  1  input operation valid
in_ready_o  output  1  block accepts an input this cycle
op_i  input  1  0 = add, 1 = subtract
a_i  input  W  operand a; precondition a_i < q_i
b_i  input  W  operand b; precondition b_i < q_i
q_i  input  W  modulus; precondition 2 <= q_i <= 2^W-1; sampled per operation
tag_i  input  TAG_W  sideband tag, passed through unchanged
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts the result
c_o  output  W  result, always in [0, q-1]
tag_o  output  TAG_W  tag of the operation that produced c_o
err_o  output  1  only present when MOD_ADDSUB_RANGE_CHK_EN is defined

Behaviour:
- Reset (rst_i=1 at clock edge): v1, v2, out_valid_o, c_o, tag_o and err_o all go to 0. Reset overrides any handshake in that cycle. In-flight operations are discarded, not completed.
- Pipeline control: advance = !v2 || out_ready_i; in_ready_o = advance (combinational). All stages move together on advance; stall freezes both stages. Bubbles are not compressed.
- Accept: an input transfers when in_valid_i && in_ready_o. Output transfers when out_valid_o && out_ready_i.
- Stage 1, on advance: v1 <= in_accept.
  - Add: register s = a+b, W+1 bits with no truncation.
  - Sub: register d = {1'b0,a} - {1'b0,b}, W+1 bits; the MSB is the borrow.
  - Also register op, q and tag.
- Stage 2, on advance: v2 <= v1. Register the corrected result:
  - Add: c = (s >= q) ? s-q : s.
  - Sub: c = borrow ? d[W-1:0] + q (mod 2^W) : d[W-1:0].
- out_valid_o = v2. c_o and tag_o are stage-2 registers and hold stable while out_valid_o && !out_ready_i.
- Latency: 2 cycles from accept to out_valid_o with no stall. Throughput: 1 op/cycle while out_ready_i=1.
- Boundaries:
  - a=b=q-1 add gives q-2 (s up to 2q-2 needs the W+1 bit).
  - a=b gives 0 for sub.
  - a=0, b=q-1 sub gives 1.
  - q=2^W-1 must work without overflow.
- A simultaneous output pop and input push in the same cycle with a full pipe is legal and sustains full rate.
- Operands violating the preconditions give an unspecified c_o; no hang, and the handshake stays correct.

Optional Feature:
MOD_ADDSUB_RANGE_CHK_EN
- Defined:
  - Stage 1 registers chk = (a_i >= q_i) || (b_i >= q_i) || (q_i < 2); stage 2 propagates it to err_o, aligned with c_o/tag_o.
  - When err_o=1, c_o is forced to 0.
  - err_o resets to 0.
- Not defined: no err_o port, no check logic, and c_o follows the arithmetic rules only.

Test Plan:
1. q=40, add a=20 b=3 tag=1, then a=20 b=21 tag=2, out_ready=1 -> c_o=23 tag 1 at cycle+2, then c_o=1 tag 2 the next cycle.
2. q=40, sub a=3 b=20 -> c_o=23; sub a=20 b=20 -> c_o=0; sub a=0 b=39 -> c_o=1.
3. q=8380417, add a=b=8380416 -> c_o=8380415; sub a=0 b=1 -> 8380416. W=23, q=2^23-1, add a=b=2^23-2 -> 2^23-3.
4. Back-to-back stream of 8 ops, out_ready_i low for 3 cycles mid-stream:
   - in_ready_o drops while stalled.
   - c_o/tag_o hold stable.
   - All 8 results arrive in order with none lost or duplicated.
5. rst_i asserted for 1 cycle with 2 ops in flight -> out_valid_o=0 next cycle, those ops never emerge, next accepted op returns after 2 cycles.
6. With MOD_ADDSUB_RANGE_CHK_EN: q=40, add a=40 b=1 -> err_o=1, c_o=0; next op a=1 b=1 -> err_o=0, c_o=2.
